conv_out_pack: RTL and testbench
================================

Name: conv_out_pack

Overview:
- Downstream stage of the 4x4 convolution engine.
- Consumes the engine's pairs of 25-bit unsigned window sums, requantizes each sum to 8 bits, and packs four pairs (8 bytes) into one 64-bit word.
- Buffers packed words in a small FIFO and presents them on a valid/ready interface to the output writer.
- The conv engine has no backpressure, so overflow is detected and flagged rather than stalled.

Parameters:
- FIFO_DEPTH, 4: number of 64-bit words buffered; power of two, minimum 2.
- IN_W, 25: width of each incoming sum.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- start_conv  in  1  asynchronous active-low reset, shared with the conv engine; low clears all state immediately.
- cfg_shift  in  5  right-shift amount for requantization, 0..24; sampled with each pair.
- in_valid  in  1  high for one cycle per completed pair (driven from the engine's write_o).
- in_data0  in  25  first sum of the pair (engine Odata0); placed in the lower byte lane.
- in_data1  in  25  second sum of the pair (engine Odata1).
- flush  in  1  one-cycle pulse: emit any partially packed word.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head when out_valid && out_ready.
- out_data  out  64  packed word; byte k is result k, in arrival order.
- out_bytes  out  4  number of valid bytes in out_data: 8 for a full word, 2/4/6 for a flushed word.
- fifo_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; set when a word is dropped because the FIFO is full.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_bytes=0, fifo_level=0, overflow=0, pack count=0, S1 stage empty.
- Requantization, per sum x:
  - r = (x + (cfg_shift==0 ? 0 : 1<<(cfg_shift-1))) >> cfg_shift, computed at 26 bits.
  - Result byte = (r > 255) ? 255 : r[7:0].
- Stage S1 (registered):
  - On in_valid, the two requantized bytes, plus flush, are registered.
  - flush travels with the data, so a flush in the same cycle as a pair includes that pair.
  - A flush with in_valid low is registered alone.
- Pack stage:
  - pack_cnt counts 0..3 pairs; the pair from S1 is written into bytes 2*pack_cnt and 2*pack_cnt+1.
  - When pack_cnt reaches 3 and a pair arrives, the word (out_bytes=8) is pushed and pack_cnt returns to 0.
  - On a registered flush with pack_cnt>0 after including any accompanying pair: push the word with unused bytes zeroed, out_bytes = 2*pairs, then pack_cnt=0.
  - A flush with nothing pending emits nothing. A flush that coincides with a full 4th pair emits only the full word.
- Latency: 4th pair with in_valid at edge N leads to out_valid high after edge N+2, assuming the FIFO was empty.
- FIFO:
  - Push succeeds if not full, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow is set (sticky until reset), and pack_cnt still resets.
  - Pop on out_valid && out_ready; fifo_level is updated the same edge.
  - Simultaneous push and pop on an empty FIFO: no pop; the word appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all pending pairs and words are discarded; no partial emission.
- cfg_shift > 24 is treated as 24.

Optional Feature:
- Macro: CONV_PACK_SATCNT_EN.
- Defined:
  - Adds output sat_count [15:0], reset 0.
  - Increments by the number of bytes clamped to 255 in each S1 capture (0, 1 or 2).
  - Saturates at 16'hFFFF.
- Undefined: port absent; no counter logic.

Decomposition:
- Package conv_pkg holds:
  - IN_W and BYTE_W=8.
  - WORD_W=64 and PAIRS_PER_WORD=4.
  - The requant function (sum, shift) -> byte, shared with future stages.
- One sub-module: conv_pack_fifo.
  - Parameterised synchronous FIFO, WIDTH=68 (data + out_bytes), DEPTH=FIFO_DEPTH.
  - Exposes full/empty/level.
  - Same clock and async active-low reset.

Test Plan:
- Full word: cfg_shift=0; pairs (1,2),(3,4),(5,6),(7,8) on consecutive in_valid; out_ready=1 -> one word 64'h0807060504030201, out_bytes=8, out_valid 2 cycles after the 4th pair.
- Rounding and saturation: cfg_shift=4; sums 24 and 23 -> bytes 2 and 1. sum 1040400 at shift 0 -> 255.
- Partial flush: two pairs (9,10),(11,12), then flush -> word 64'h0C0B0A09, out_bytes=4. A second flush emits nothing.
- Backpressure/overflow: FIFO_DEPTH=4; out_ready=0; push 5 full words -> fifo_level=4, overflow=1. Release out_ready -> the first 4 words drain in order.
- Reset mid-word: 3 pairs, then start_conv low for 1 cycle -> all outputs 0. Next 4 pairs produce exactly one word containing only the new pairs.
- With CONV_PACK_SATCNT_EN: shift 0; pairs (300,5),(256,256) -> sat_count=3.

Source files
------------

// File: rtl/conv_out_pack_pkg.sv
// Shared types, widths and the requantization helper for the conv output path.
// Pure package: no logic and no latency.
// Holds no state, so there is no backpressure.
package conv_pkg;
  localparam int IN_W           = 25;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 64;
  localparam int PAIRS_PER_WORD = 4;
  localparam int MAX_SHIFT      = 24;
  localparam int RAW_W          = IN_W + 1;
  localparam int FIFO_W         = WORD_W + 4;

  // Round-half-up right shift at one bit of headroom; shifts above 24 act as 24.
  function automatic logic [RAW_W-1:0] requant_raw(input logic [IN_W-1:0] sum,
                                                   input logic [4:0] shift);
    logic [4:0]       s;
    logic [RAW_W-1:0] rnd;
    s   = (shift > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : shift;
    rnd = (s == 5'd0) ? '0 : (RAW_W'(1) << (s - 5'd1));
    return ({1'b0, sum} + rnd) >> s;
  endfunction

  // Requantized byte, clamped to 255.
  function automatic logic [BYTE_W-1:0] requant(input logic [IN_W-1:0] sum,
                                                input logic [4:0] shift);
    logic [RAW_W-1:0] r;
    r = requant_raw(sum, shift);
    return (r > RAW_W'(255)) ? 8'hFF : r[BYTE_W-1:0];
  endfunction

  // True when the requantized value had to be clamped.
  function automatic logic requant_sat(input logic [IN_W-1:0] sum,
                                       input logic [4:0] shift);
    return requant_raw(sum, shift) > RAW_W'(255);
  endfunction
endpackage

// File: rtl/conv_out_pack_if.sv
// Output stream of packed words towards the output writer.
// Wires only: no latency.
// Standard valid/ready; a word moves when out_valid && out_ready.
interface conv_out_pack_if;
  import conv_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic [3:0]        out_bytes;

  modport master (output out_valid, output out_data, output out_bytes, input out_ready);
  modport slave  (input out_valid, input out_data, input out_bytes, output out_ready);
endinterface

// File: rtl/conv_out_pack_fifo.sv
// Synchronous FIFO of packed words plus byte counts; read data reads as zero when empty.
// Write visible on the read side one cycle after the write edge.
// Caller must not write when full without a same-cycle read, nor read when empty.
module conv_pack_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array; no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign full   = (level == LW'(DEPTH));
  assign empty  = (level == '0);
  assign rd_dat = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/conv_out_pack.sv
// Requantizes conv-engine sum pairs to bytes and packs four pairs per 64-bit word.
// Two cycles from the 4th pair's in_valid edge to the word entering the FIFO.
// No input backpressure: a word arriving at a full FIFO is dropped and overflow latches.
// Optional CONV_PACK_SATCNT_EN adds sat_count, the number of clamped bytes.
module conv_out_pack #(
  parameter int FIFO_DEPTH = 4,
  parameter int IN_W       = 25
) (
  input  logic                          clk,
  input  logic                          start_conv,
  input  logic [4:0]                    cfg_shift,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_data0,
  input  logic [IN_W-1:0]               in_data1,
  input  logic                          flush,
  conv_out_pack_if.master               out_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef CONV_PACK_SATCNT_EN
  , output logic [15:0]                 sat_count
`endif
);
  import conv_pkg::*;

  logic              s1_vld;
  logic              s1_flush;
  logic [BYTE_W-1:0] s1_b0;
  logic [BYTE_W-1:0] s1_b1;

  logic [1:0]        pack_cnt, pack_cnt_nxt;
  logic [WORD_W-1:0] acc, acc_nxt, merged;
  logic              emit;
  logic [3:0]        emit_bytes;

  logic              push_vld;
  logic [FIFO_W-1:0] push_dat;
  logic [FIFO_W-1:0] head;
  logic              fifo_full, fifo_empty, pop, wr;

  // S1: capture requantized bytes; flush rides alongside so it covers the same-cycle pair.
  always_ff @(posedge clk or negedge start_conv) begin
    if (!start_conv) begin
      s1_vld   <= 1'b0;
      s1_flush <= 1'b0;
      s1_b0    <= '0;
      s1_b1    <= '0;
    end else begin
      s1_vld   <= in_valid;
      s1_flush <= flush;
      if (in_valid) begin
        s1_b0 <= requant(in_data0, cfg_shift);
        s1_b1 <= requant(in_data1, cfg_shift);
      end
    end
  end

  // Pack: merge the S1 pair into its lane, decide whether a word leaves this cycle.
  always_comb begin
    merged       = acc;
    emit         = 1'b0;
    emit_bytes   = 4'd0;
    pack_cnt_nxt = pack_cnt;
    acc_nxt      = acc;
    if (s1_vld) merged[{pack_cnt, 4'b0} +: 16] = {s1_b1, s1_b0};
    if (s1_vld && pack_cnt == 2'd3) begin
      emit       = 1'b1;
      emit_bytes = 4'd8;
    end else if (s1_flush && (s1_vld || pack_cnt != 2'd0)) begin
      emit       = 1'b1;
      emit_bytes = {1'b0, pack_cnt + 2'(s1_vld), 1'b0};
    end
    if (emit) begin
      pack_cnt_nxt = 2'd0;
      acc_nxt      = '0;
    end else if (s1_vld) begin
      pack_cnt_nxt = pack_cnt + 2'd1;
      acc_nxt      = merged;
    end
  end

  // Pack state plus a registered push toward the FIFO.
  always_ff @(posedge clk or negedge start_conv) begin
    if (!start_conv) begin
      pack_cnt <= 2'd0;
      acc      <= '0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      pack_cnt <= pack_cnt_nxt;
      acc      <= acc_nxt;
      push_vld <= emit;
      if (emit) push_dat <= {emit_bytes, merged};
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop = !fifo_empty && out_if.out_ready;
  assign wr  = push_vld && (!fifo_full || pop);

  conv_pack_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (start_conv),
    .wr_en  (wr),
    .wr_dat (push_dat),
    .rd_en  (pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Sticky drop flag.
  always_ff @(posedge clk or negedge start_conv) begin
    if (!start_conv)                        overflow <= 1'b0;
    else if (push_vld && fifo_full && !pop) overflow <= 1'b1;
  end

  assign out_if.out_valid = !fifo_empty;
  assign out_if.out_data  = head[WORD_W-1:0];
  assign out_if.out_bytes = head[FIFO_W-1:WORD_W];

`ifdef CONV_PACK_SATCNT_EN
  logic [1:0]  sat_inc;
  logic [16:0] sat_sum;
  assign sat_inc = in_valid ? (2'(requant_sat(in_data0, cfg_shift)) +
                               2'(requant_sat(in_data1, cfg_shift))) : 2'd0;
  assign sat_sum = {1'b0, sat_count} + 17'(sat_inc);

  // Count clamped bytes at capture time, holding at all-ones.
  always_ff @(posedge clk or negedge start_conv) begin
    if (!start_conv) sat_count <= '0;
    else             sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`endif
endmodule

// File: tb/tb_conv_out_pack.sv
// Self-checking bench for conv_out_pack: table vectors, directed corners, random scoreboard.
// Reference model works on byte queues and a cycle-indexed word schedule.
// Consumer readiness is driven by the bench to exercise backpressure and overflow.
module tb_conv_out_pack;
  localparam int DEPTH = 4;

  logic        clk;
  logic        start_conv;
  logic [4:0]  cfg_shift;
  logic        in_valid;
  logic [24:0] in_data0;
  logic [24:0] in_data1;
  logic        flush;
  logic [2:0]  fifo_level;
  logic        overflow;
`ifdef CONV_PACK_SATCNT_EN
  logic [15:0] sat_count;
`endif

  conv_out_pack_if bus();

  conv_out_pack #(.FIFO_DEPTH(DEPTH), .IN_W(25)) dut (
    .clk        (clk),
    .start_conv (start_conv),
    .cfg_shift  (cfg_shift),
    .in_valid   (in_valid),
    .in_data0   (in_data0),
    .in_data1   (in_data1),
    .flush      (flush),
    .out_if     (bus.master),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef CONV_PACK_SATCNT_EN
    , .sat_count (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          nb;
    int          due;
  } mword_t;

  typedef struct {
    int sh;
    int x0;
    int x1;
    int e0;
    int e1;
  } vec_t;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     pb[$];
  mword_t sched[$];
  mword_t mq[$];
  bit     m_ovf = 0;
  int     m_sat = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rq_raw(input int x, input int sh);
    int     s;
    longint div;
    s   = (sh > 24) ? 24 : sh;
    div = longint'(1) << s;
    return int'((longint'(x) + div / 2) / div);
  endfunction

  function automatic int rq(input int x, input int sh);
    int r;
    r = rq_raw(x, sh);
    return (r > 255) ? 255 : r;
  endfunction

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, mq.size() > 0);
    chk("fifo_level", fifo_level, mq.size());
    chk("overflow", overflow, m_ovf);
    if (mq.size() > 0) begin
      chk("out_data", bus.out_data, mq[0].data);
      chk("out_bytes", bus.out_bytes, mq[0].nb);
    end
`ifdef CONV_PACK_SATCNT_EN
    chk("sat_count", sat_count, m_sat);
`endif
  endtask

  // One clock: compare, drive, advance the model, clock, settle to the next negedge.
  task automatic step(input bit iv, input int x0, input int x1, input int sh,
                      input bit fl, input bit rdy);
    mword_t w;
    bit     pop;
    check_outputs();
    in_valid      = iv;
    in_data0      = 25'(x0);
    in_data1      = 25'(x1);
    cfg_shift     = 5'(sh);
    flush         = fl;
    bus.out_ready = rdy;
    if (iv) begin
      pb.push_back(rq(x0, sh));
      pb.push_back(rq(x1, sh));
    end
    if (pb.size() == 8 || (fl && pb.size() > 0)) begin
      w.data = '0;
      for (int i = 0; i < pb.size(); i++) w.data[8*i +: 8] = 8'(pb[i]);
      w.nb  = pb.size();
      w.due = cyc + 3;
      sched.push_back(w);
      pb.delete();
    end
    @(posedge clk);
    cyc++;
    if (iv) begin
      if (rq_raw(x0, sh) > 255) m_sat++;
      if (rq_raw(x1, sh) > 255) m_sat++;
      if (m_sat > 65535) m_sat = 65535;
    end
    pop = (mq.size() > 0) && rdy;
    if (pop) w = mq.pop_front();
    while (sched.size() > 0 && sched[0].due == cyc) begin
      w = sched.pop_front();
      if (mq.size() < DEPTH) mq.push_back(w);
      else                   m_ovf = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, rdy);
  endtask

  task automatic do_reset();
    start_conv    = 1'b0;
    in_valid      = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_bytes", bus.out_bytes, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
`ifdef CONV_PACK_SATCNT_EN
    chk("rst_sat_count", sat_count, 0);
`endif
    pb.delete();
    sched.delete();
    mq.delete();
    m_ovf = 1'b0;
    m_sat = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    start_conv = 1'b1;
  endtask

  task automatic run_table();
    vec_t        tbl[8];
    logic [63:0] exp_w;
    tbl[0] = '{0, 1, 2, 1, 2};
    tbl[1] = '{0, 3, 4, 3, 4};
    tbl[2] = '{0, 5, 6, 5, 6};
    tbl[3] = '{0, 7, 8, 7, 8};
    tbl[4] = '{4, 24, 23, 2, 1};
    tbl[5] = '{0, 1040400, 255, 255, 255};
    tbl[6] = '{24, 33554431, 8388608, 2, 1};
    tbl[7] = '{31, 8388608, 8388607, 1, 0};
    for (int w = 0; w < 2; w++) begin
      exp_w = '0;
      for (int i = 0; i < 4; i++) begin
        step(1'b1, tbl[4*w+i].x0, tbl[4*w+i].x1, tbl[4*w+i].sh, 1'b0, 1'b0);
        exp_w[16*i +: 16] = {8'(tbl[4*w+i].e1), 8'(tbl[4*w+i].e0)};
      end
      chk("lat_edge1_valid", bus.out_valid, 0);
      idle(1, 1'b0);
      chk("lat_edge2_valid", bus.out_valid, 0);
      idle(1, 1'b0);
      chk("lat_edge3_valid", bus.out_valid, 1);
      chk("tbl_word", bus.out_data, exp_w);
      chk("tbl_bytes", bus.out_bytes, 8);
      idle(1, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    start_conv    = 1'b1;
    cfg_shift     = '0;
    in_valid      = 1'b0;
    in_data0      = '0;
    in_data1      = '0;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    run_table();

    // Partial flush, then a flush with nothing pending.
    step(1'b1, 9, 10, 0, 1'b0, 1'b0);
    step(1'b1, 11, 12, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle(2, 1'b0);
    chk("flush_word", bus.out_data, 64'h0C0B0A09);
    chk("flush_bytes", bus.out_bytes, 4);
    idle(1, 1'b1);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("empty_flush_level", fifo_level, 0);

    // Flush on the 4th pair yields only the full word.
    for (int i = 0; i < 4; i++) step(1'b1, 20 + i, 30 + i, 0, i == 3, 1'b0);
    idle(4, 1'b0);
    chk("flush_full_level", fifo_level, 1);
    chk("flush_full_bytes", bus.out_bytes, 8);
    idle(2, 1'b1);

    // Backpressure: five full words against a 4-deep FIFO.
    do_reset();
    for (int p = 0; p < 20; p++) step(1'b1, 2*p + 1, 2*p + 2, 0, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("ovf_level", fifo_level, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", bus.out_data, 64'h0807060504030201);
    idle(6, 1'b1);
    chk("drain_level", fifo_level, 0);

    // Reset in the middle of a word.
    for (int p = 0; p < 3; p++) step(1'b1, 50 + p, 60 + p, 0, 1'b0, 1'b0);
    do_reset();
    for (int p = 0; p < 4; p++) step(1'b1, 100 + 2*p, 101 + 2*p, 0, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("rstmid_level", fifo_level, 1);
    chk("rstmid_word", bus.out_data, 64'h6B6A696867666564);
    idle(2, 1'b1);

`ifdef CONV_PACK_SATCNT_EN
    do_reset();
    step(1'b1, 300, 5, 0, 1'b0, 1'b1);
    step(1'b1, 256, 256, 0, 1'b0, 1'b1);
    chk("sat_count_3", sat_count, 3);
`endif

    // Random traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int x0, x1;
      x0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 33554431)) : int'($urandom_range(0, 4095));
      x1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 33554431)) : int'($urandom_range(0, 4095));
      step($urandom_range(0, 2) != 0, x0, x1, int'($urandom_range(0, 31)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
    end
    idle(10, 1'b1);
    check_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
